eth_tx_serializer: RTL and testbench

ETH_TX_SERIALIZER -- requirements
Module: eth_tx_serializer

---
 rtl/eth_tx_pkg.sv | 29 ++
 rtl/eth_tx_serializer.sv | 131 +++++++++++++
 tb/tb_eth_tx_serializer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the RMII transmit serializer.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        IFG
    } tx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE          = 8'h55;
    localparam logic [7:0] SFD_BYTE               = 8'hD5;
    localparam int         DEFAULT_IFG_CYCLES     = 48;
    localparam int         DEFAULT_PREAMBLE_BYTES = 7;

    // Bytes leave the MAC least-significant dibit first.
    function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] idx);
        logic [1:0] d;
        case (idx)
            2'd0:    d = b[1:0];
            2'd1:    d = b[3:2];
            2'd2:    d = b[5:4];
            default: d = b[7:6];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/eth_tx_serializer.sv
// Byte-stream to RMII dibit serializer: prepends preamble/SFD to each frame
// and enforces the inter-frame gap before accepting the next frame.
module eth_tx_serializer
    import eth_tx_pkg::*;
#(
    parameter int IFG_CYCLES     = DEFAULT_IFG_CYCLES,
    parameter int PREAMBLE_BYTES = DEFAULT_PREAMBLE_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    output logic       axiir,
    output logic       axiov,
    output logic [1:0] axiod
);

    localparam int BYTE_W = $clog2(PREAMBLE_BYTES + 1);
    localparam int IFG_W  = $clog2(IFG_CYCLES + 1);
    localparam logic [BYTE_W-1:0] LAST_PRE = BYTE_W'(PREAMBLE_BYTES - 1);
    localparam logic [IFG_W-1:0]  LAST_IFG = IFG_W'(IFG_CYCLES - 1);

    tx_state_t         state, state_nxt;
    logic [7:0]        byte_reg, byte_nxt;
    logic [1:0]        dibit_cnt, dibit_nxt;
    logic [BYTE_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [IFG_W-1:0]  ifg_cnt, ifg_nxt;
    logic              ov_nxt;
    logic [1:0]        od_nxt;
    logic [1:0]        step;

    // State and counters always describe the dibit currently on the wire.
    assign axiir = (state == IDLE) || ((state == DATA) && (dibit_cnt == 2'd3));
    assign step  = dibit_cnt + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_reg  <= 8'h00;
            dibit_cnt <= 2'd0;
            byte_cnt  <= '0;
            ifg_cnt   <= '0;
            axiov     <= 1'b0;
            axiod     <= 2'b00;
        end else begin
            state     <= state_nxt;
            byte_reg  <= byte_nxt;
            dibit_cnt <= dibit_nxt;
            byte_cnt  <= byte_cnt_nxt;
            ifg_cnt   <= ifg_nxt;
            axiov     <= ov_nxt;
            axiod     <= od_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_nxt     = byte_reg;
        dibit_nxt    = dibit_cnt;
        byte_cnt_nxt = byte_cnt;
        ifg_nxt      = ifg_cnt;
        ov_nxt       = axiov;
        od_nxt       = axiod;

        case (state)
            IDLE: begin
                ov_nxt = 1'b0;
                od_nxt = 2'b00;
                if (axiiv) begin
                    byte_nxt     = axiid;
                    dibit_nxt    = 2'd0;
                    byte_cnt_nxt = '0;
                    state_nxt    = PREAMBLE;
                    ov_nxt       = 1'b1;
                    od_nxt       = dibit_sel(PREAMBLE_BYTE, 2'd0);
                end
            end
            PREAMBLE: begin
                dibit_nxt = step;
                od_nxt    = dibit_sel(PREAMBLE_BYTE, step);
                if (dibit_cnt == 2'd3) begin
                    if (byte_cnt == LAST_PRE) begin
                        state_nxt = SFD;
                        od_nxt    = dibit_sel(SFD_BYTE, 2'd0);
                    end else begin
                        byte_cnt_nxt = byte_cnt + BYTE_W'(1);
                    end
                end
            end
            SFD: begin
                dibit_nxt = step;
                od_nxt    = dibit_sel(SFD_BYTE, step);
                if (dibit_cnt == 2'd3) begin
                    state_nxt = DATA;
                    od_nxt    = dibit_sel(byte_reg, 2'd0);
                end
            end
            DATA: begin
                dibit_nxt = step;
                od_nxt    = dibit_sel(byte_reg, step);
                if (dibit_cnt == 2'd3) begin
                    // Ready is high here, so axiiv alone decides continue vs end of frame.
                    if (axiiv) begin
                        byte_nxt = axiid;
                        od_nxt   = dibit_sel(axiid, 2'd0);
                    end else begin
                        state_nxt = IFG;
                        ov_nxt    = 1'b0;
                        od_nxt    = 2'b00;
                        ifg_nxt   = '0;
                    end
                end
            end
            IFG: begin
                ov_nxt = 1'b0;
                od_nxt = 2'b00;
                if (ifg_cnt == LAST_IFG) begin
                    state_nxt = IDLE;
                end else begin
                    ifg_nxt = ifg_cnt + IFG_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ov_nxt    = 1'b0;
                od_nxt    = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_tx_serializer.sv
// Directed self-checking bench for eth_tx_serializer using default parameters.
module tb_eth_tx_serializer;

    logic       clk;
    logic       rst_n;
    logic       axiiv;
    logic [7:0] axiid;
    logic       axiir;
    logic       axiov;
    logic [1:0] axiod;

    int tests = 0;
    int fails = 0;

    logic [7:0] payload[$];
    logic [1:0] exp_payload[$];
    logic [1:0] got[$];
    int         readyq[$];

    eth_tx_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiir (axiir),
        .axiov (axiov),
        .axiod (axiod)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sends payload as one frame and captures every dibit while axiov is high.
    task automatic run_frame(input bit toggle);
        int idx;
        int guard;
        bit acc;
        got.delete();
        readyq.delete();
        axiiv = 1'b1;
        axiid = payload[0];
        guard = 0;
        while (!axiir && guard < 200) begin
            tick();
            guard++;
        end
        check_output("ready_wait", int'(guard < 200), 1);
        tick();
        idx   = 1;
        guard = 0;
        while (axiov && guard < 400) begin
            got.push_back(axiod);
            if (axiir) begin
                readyq.push_back(got.size() - 1);
                axiiv = (idx < payload.size());
                if (axiiv) axiid = payload[idx];
            end else if (toggle) begin
                axiiv = guard[0];
                axiid = 8'(guard * 37 + 5);
            end else begin
                axiiv = (idx < payload.size());
                if (axiiv) axiid = payload[idx];
            end
            acc = axiiv && axiir;
            tick();
            if (acc) idx++;
            guard++;
        end
        axiiv = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_len);
        logic [1:0] exp[$];
        for (int i = 0; i < 28; i++) exp.push_back(2'b01);
        exp.push_back(2'b01);
        exp.push_back(2'b01);
        exp.push_back(2'b01);
        exp.push_back(2'b11);
        foreach (exp_payload[i]) exp.push_back(exp_payload[i]);
        check_output({tag, "_len"}, got.size(), exp_len);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check_output($sformatf("%s_dibit%0d", tag, i), got[i], exp[i]);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        axiiv = 1'b0;
        axiid = 8'h00;
        #3;
        check_output("rst_axiov", axiov, 0);
        check_output("rst_axiod", axiod, 0);
        check_output("rst_axiir", axiir, 1);
        tick();
        check_output("rst_hold_axiov", axiov, 0);
        #4 rst_n = 1'b1;

        // Single byte A5
        payload     = '{8'hA5};
        exp_payload = '{2'b01, 2'b01, 2'b10, 2'b10};
        run_frame(1'b0);
        check_frame("a5", 36);

        // Three bytes back to back, ready pulses on last dibit of each byte
        payload     = '{8'h12, 8'h34, 8'h56};
        exp_payload = '{2'b10, 2'b00, 2'b01, 2'b00,
                        2'b00, 2'b01, 2'b11, 2'b00,
                        2'b10, 2'b01, 2'b01, 2'b01};
        run_frame(1'b0);
        check_frame("multi", 44);
        check_output("multi_ready_cnt", readyq.size(), 3);
        if (readyq.size() == 3) begin
            check_output("multi_ready0", readyq[0], 35);
            check_output("multi_ready1", readyq[1], 39);
            check_output("multi_ready2", readyq[2], 43);
        end

        // New byte offered right after frame end must wait out the gap
        check_output("ifg_axiov", axiov, 0);
        axiiv = 1'b1;
        axiid = 8'h9C;
        n = 0;
        while (!axiir && n < 300) begin
            tick();
            n++;
        end
        check_output("ifg_ready_low", n, 48);
        check_output("ifg_idle_axiov", axiov, 0);
        tick();
        axiiv = 1'b0;
        check_output("ifg_next_axiov", axiov, 1);
        check_output("ifg_next_axiod", axiod, 1);
        n = 0;
        while (axiov && n < 400) begin
            tick();
            n++;
        end
        check_output("ifg_next_len", n, 36);

        // Garbage on axiiv/axiid while not ready must not disturb the frame
        payload     = '{8'h0F};
        exp_payload = '{2'b11, 2'b11, 2'b00, 2'b00};
        run_frame(1'b1);
        check_frame("toggle", 36);

        // Reset in the middle of the payload truncates the frame immediately
        axiiv = 1'b1;
        axiid = 8'h3C;
        n = 0;
        while (!axiir && n < 200) begin
            tick();
            n++;
        end
        tick();
        axiiv = 1'b0;
        repeat (34) tick();
        check_output("mid_axiov", axiov, 1);
        check_output("mid_axiod", axiod, 3);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_axiov", axiov, 0);
        check_output("async_axiod", axiod, 0);
        check_output("async_axiir", axiir, 1);
        tick();
        check_output("async_hold_axiov", axiov, 0);
        #2 rst_n = 1'b1;
        check_output("post_rst_axiir", axiir, 1);

        payload     = '{8'hFF};
        exp_payload = '{2'b11, 2'b11, 2'b11, 2'b11};
        run_frame(1'b0);
        check_frame("post_rst", 36);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
